roce_qp_context_table: RTL and testbench

Per-queue-pair context store sitting directly upstream of the RoCE work-queue stage, which issues context requests to it. The table answers those lookup requests with the full QP context one cycle later, and accepts three kinds of update:
- full-entry writes from the connection-management/config path;
- PSN advances from the TX header path;
- error events.

Local QPNs are mapped as 0x000100 + index.

---
 rtl/roce_qp_context_table.sv | 142 ++++++++++++++
 tb/tb_roce_qp_context_table.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/roce_qp_context_table.sv
// Per-QP context store for the RoCE work-queue stage: one-cycle registered lookups,
// plus config writes, TX PSN advances and error events applied per entry.
module roce_qp_context_table #(
  parameter int MAX_QUEUE_PAIRS = 4,
  localparam int IDX_W = $clog2(MAX_QUEUE_PAIRS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_cfg_valid,
  input  logic [23:0]      s_cfg_loc_qpn,
  input  logic [2:0]       s_cfg_state,
  input  logic [31:0]      s_cfg_r_key,
  input  logic [23:0]      s_cfg_rem_qpn,
  input  logic [23:0]      s_cfg_rem_psn,
  input  logic [23:0]      s_cfg_loc_psn,
  input  logic [31:0]      s_cfg_rem_ip_addr,
  input  logic [63:0]      s_cfg_rem_addr,
  input  logic             s_psn_upd_valid,
  input  logic [23:0]      s_psn_upd_loc_qpn,
  input  logic [23:0]      s_psn_upd_npkts,
  input  logic             s_err_valid,
  input  logic [23:0]      s_err_loc_qpn,
  input  logic             s_qp_context_req,
  input  logic [23:0]      s_qp_local_qpn_req,
  output logic             m_qp_context_valid,
  output logic [2:0]       m_qp_state,
  output logic [31:0]      m_qp_r_key,
  output logic [23:0]      m_qp_rem_qpn,
  output logic [23:0]      m_qp_loc_qpn,
  output logic [23:0]      m_qp_rem_psn,
  output logic [23:0]      m_qp_loc_psn,
  output logic [31:0]      m_qp_rem_ip_addr,
  output logic [63:0]      m_qp_rem_addr,
  output logic [IDX_W:0]   m_rts_count
);

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_INIT     = 3'd1,
    ST_RTR      = 3'd2,
    ST_RTS      = 3'd3,
    ST_SQ_DRAIN = 3'd4,
    ST_SQ_ERROR = 3'd5,
    ST_ERROR    = 3'd6
  } qp_state_e;

  typedef struct packed {
    qp_state_e   state;
    logic [31:0] r_key;
    logic [23:0] rem_qpn;
    logic [23:0] rem_psn;
    logic [23:0] loc_psn;
    logic [31:0] rem_ip_addr;
    logic [63:0] rem_addr;
  } qp_entry_t;

  qp_entry_t       ent     [MAX_QUEUE_PAIRS];
  qp_entry_t       ent_nxt [MAX_QUEUE_PAIRS];
  logic [IDX_W:0]  rts_nxt;

  // Local QPNs live at 0x000100 + index; anything outside that window is foreign.
  function automatic logic qpn_valid(input logic [23:0] qpn);
    return (qpn[23:8] == 16'h0001) && ((qpn[7:0] >> IDX_W) == 8'd0);
  endfunction

  logic cfg_ok, psn_ok, err_ok;
  assign cfg_ok = s_cfg_valid     && qpn_valid(s_cfg_loc_qpn);
  assign psn_ok = s_psn_upd_valid && qpn_valid(s_psn_upd_loc_qpn);
  assign err_ok = s_err_valid     && qpn_valid(s_err_loc_qpn);

  // Per-entry update with priority cfg > err > psn on a shared index.
  always_comb begin
    // NOTE: every comb output gets its default first, so no path can infer a latch.
    rts_nxt = '0;
    for (int i = 0; i < MAX_QUEUE_PAIRS; i++) begin
      ent_nxt[i] = ent[i];
      if (cfg_ok && s_cfg_loc_qpn[IDX_W-1:0] == IDX_W'(i)) begin
        ent_nxt[i].state       = (s_cfg_state == 3'd7) ? ST_ERROR : qp_state_e'(s_cfg_state);
        ent_nxt[i].r_key       = s_cfg_r_key;
        ent_nxt[i].rem_qpn     = s_cfg_rem_qpn;
        ent_nxt[i].rem_psn     = s_cfg_rem_psn;
        ent_nxt[i].loc_psn     = s_cfg_loc_psn;
        ent_nxt[i].rem_ip_addr = s_cfg_rem_ip_addr;
        ent_nxt[i].rem_addr    = s_cfg_rem_addr;
      end else if (err_ok && s_err_loc_qpn[IDX_W-1:0] == IDX_W'(i)) begin
        if (ent[i].state != ST_RESET) ent_nxt[i].state = ST_ERROR;
      end else if (psn_ok && s_psn_upd_loc_qpn[IDX_W-1:0] == IDX_W'(i)) begin
        if (ent[i].state == ST_RTS) ent_nxt[i].rem_psn = ent[i].rem_psn + s_psn_upd_npkts;
      end
      if (ent_nxt[i].state == ST_RTS) rts_nxt = rts_nxt + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the table is a small flop array, so it is reset like any other state; a RAM would not be.
    if (rst) begin
      for (int i = 0; i < MAX_QUEUE_PAIRS; i++) ent[i] <= '0;
      m_rts_count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep lookups reading the pre-update entry.
      for (int i = 0; i < MAX_QUEUE_PAIRS; i++) ent[i] <= ent_nxt[i];
      m_rts_count <= rts_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_qp_context_valid <= 1'b0;
      m_qp_state         <= '0;
      m_qp_r_key         <= '0;
      m_qp_rem_qpn       <= '0;
      m_qp_loc_qpn       <= '0;
      m_qp_rem_psn       <= '0;
      m_qp_loc_psn       <= '0;
      m_qp_rem_ip_addr   <= '0;
      m_qp_rem_addr      <= '0;
    end else begin
      m_qp_context_valid <= s_qp_context_req;
      if (s_qp_context_req) begin
        m_qp_loc_qpn <= s_qp_local_qpn_req;
        if (qpn_valid(s_qp_local_qpn_req)) begin
          m_qp_state       <= ent[s_qp_local_qpn_req[IDX_W-1:0]].state;
          m_qp_r_key       <= ent[s_qp_local_qpn_req[IDX_W-1:0]].r_key;
          m_qp_rem_qpn     <= ent[s_qp_local_qpn_req[IDX_W-1:0]].rem_qpn;
          m_qp_rem_psn     <= ent[s_qp_local_qpn_req[IDX_W-1:0]].rem_psn;
          m_qp_loc_psn     <= ent[s_qp_local_qpn_req[IDX_W-1:0]].loc_psn;
          m_qp_rem_ip_addr <= ent[s_qp_local_qpn_req[IDX_W-1:0]].rem_ip_addr;
          m_qp_rem_addr    <= ent[s_qp_local_qpn_req[IDX_W-1:0]].rem_addr;
        end else begin
          m_qp_state       <= '0;
          m_qp_r_key       <= '0;
          m_qp_rem_qpn     <= '0;
          m_qp_rem_psn     <= '0;
          m_qp_loc_psn     <= '0;
          m_qp_rem_ip_addr <= '0;
          m_qp_rem_addr    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_roce_qp_context_table.sv
// Directed bench for roce_qp_context_table: reset, config, PSN wrap, priority,
// read-before-write, invalid QPNs and back-to-back lookups.
module tb_roce_qp_context_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_cfg_valid;
  logic [23:0] s_cfg_loc_qpn;
  logic [2:0]  s_cfg_state;
  logic [31:0] s_cfg_r_key;
  logic [23:0] s_cfg_rem_qpn, s_cfg_rem_psn, s_cfg_loc_psn;
  logic [31:0] s_cfg_rem_ip_addr;
  logic [63:0] s_cfg_rem_addr;
  logic        s_psn_upd_valid;
  logic [23:0] s_psn_upd_loc_qpn, s_psn_upd_npkts;
  logic        s_err_valid;
  logic [23:0] s_err_loc_qpn;
  logic        s_qp_context_req;
  logic [23:0] s_qp_local_qpn_req;
  logic        m_qp_context_valid;
  logic [2:0]  m_qp_state;
  logic [31:0] m_qp_r_key;
  logic [23:0] m_qp_rem_qpn, m_qp_loc_qpn, m_qp_rem_psn, m_qp_loc_psn;
  logic [31:0] m_qp_rem_ip_addr;
  logic [63:0] m_qp_rem_addr;
  logic [2:0]  m_rts_count;

  int errors = 0;
  int checks = 0;

  roce_qp_context_table #(.MAX_QUEUE_PAIRS(4)) dut (
    .clk(clk), .rst(rst),
    .s_cfg_valid(s_cfg_valid), .s_cfg_loc_qpn(s_cfg_loc_qpn), .s_cfg_state(s_cfg_state),
    .s_cfg_r_key(s_cfg_r_key), .s_cfg_rem_qpn(s_cfg_rem_qpn), .s_cfg_rem_psn(s_cfg_rem_psn),
    .s_cfg_loc_psn(s_cfg_loc_psn), .s_cfg_rem_ip_addr(s_cfg_rem_ip_addr),
    .s_cfg_rem_addr(s_cfg_rem_addr),
    .s_psn_upd_valid(s_psn_upd_valid), .s_psn_upd_loc_qpn(s_psn_upd_loc_qpn),
    .s_psn_upd_npkts(s_psn_upd_npkts),
    .s_err_valid(s_err_valid), .s_err_loc_qpn(s_err_loc_qpn),
    .s_qp_context_req(s_qp_context_req), .s_qp_local_qpn_req(s_qp_local_qpn_req),
    .m_qp_context_valid(m_qp_context_valid), .m_qp_state(m_qp_state),
    .m_qp_r_key(m_qp_r_key), .m_qp_rem_qpn(m_qp_rem_qpn), .m_qp_loc_qpn(m_qp_loc_qpn),
    .m_qp_rem_psn(m_qp_rem_psn), .m_qp_loc_psn(m_qp_loc_psn),
    .m_qp_rem_ip_addr(m_qp_rem_ip_addr), .m_qp_rem_addr(m_qp_rem_addr),
    .m_rts_count(m_rts_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic set_cfg(input logic [23:0] qpn, input logic [2:0] st, input logic [31:0] rk,
                         input logic [23:0] rq, input logic [23:0] rp, input logic [23:0] lp,
                         input logic [31:0] ip, input logic [63:0] ad);
    s_cfg_valid = 1'b1; s_cfg_loc_qpn = qpn; s_cfg_state = st; s_cfg_r_key = rk;
    s_cfg_rem_qpn = rq; s_cfg_rem_psn = rp; s_cfg_loc_psn = lp;
    s_cfg_rem_ip_addr = ip; s_cfg_rem_addr = ad;
  endtask

  task automatic idle_inputs();
    s_cfg_valid = 1'b0; s_psn_upd_valid = 1'b0; s_err_valid = 1'b0; s_qp_context_req = 1'b0;
  endtask

  task automatic cfg(input logic [23:0] qpn, input logic [2:0] st, input logic [23:0] rp);
    set_cfg(qpn, st, 32'h0, 24'h0, rp, 24'h0, 32'h0, 64'h0);
    @(negedge clk); idle_inputs();
  endtask

  task automatic psn_upd(input logic [23:0] qpn, input logic [23:0] n);
    s_psn_upd_valid = 1'b1; s_psn_upd_loc_qpn = qpn; s_psn_upd_npkts = n;
    @(negedge clk); idle_inputs();
  endtask

  task automatic err_evt(input logic [23:0] qpn);
    s_err_valid = 1'b1; s_err_loc_qpn = qpn;
    @(negedge clk); idle_inputs();
  endtask

  // Returns one negedge after the request's posedge, with the response on the outputs.
  task automatic lookup(input logic [23:0] qpn);
    s_qp_context_req = 1'b1; s_qp_local_qpn_req = qpn;
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    s_qp_context_req = 1'b1; s_qp_local_qpn_req = 24'h000101;
    @(negedge clk);
    checks++; if (m_qp_context_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", m_qp_context_valid); end
    checks++; if (m_rts_count !== 3'd0) begin errors++; $display("FAIL reset_rts: got %0d want 0", m_rts_count); end
    @(negedge clk); rst = 1'b0; idle_inputs();
    @(negedge clk);
    checks++; if (m_qp_context_valid !== 1'b0) begin errors++; $display("FAIL reset_no_resp: got %b want 0", m_qp_context_valid); end
    lookup(24'h000101);
    checks++; if (m_qp_context_valid !== 1'b1) begin errors++; $display("FAIL reset_lookup_valid: got %b want 1", m_qp_context_valid); end
    checks++; if (m_qp_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", m_qp_state); end
    checks++; if ({m_qp_r_key, m_qp_rem_qpn, m_qp_rem_psn, m_qp_loc_psn, m_qp_rem_ip_addr, m_qp_rem_addr} !== '0)
      begin errors++; $display("FAIL reset_fields: got nonzero r_key=%h rem_psn=%h want 0", m_qp_r_key, m_qp_rem_psn); end
    checks++; if (m_qp_loc_qpn !== 24'h000101) begin errors++; $display("FAIL reset_loc_qpn: got %h want 000101", m_qp_loc_qpn); end
    @(negedge clk);
    checks++; if (m_qp_context_valid !== 1'b0) begin errors++; $display("FAIL resp_one_cycle: got %b want 0", m_qp_context_valid); end
    checks++; if (m_qp_loc_qpn !== 24'h000101) begin errors++; $display("FAIL resp_hold: got %h want 000101", m_qp_loc_qpn); end
    // Error on a RESET entry must leave it in RESET.
    err_evt(24'h000103);
    lookup(24'h000103);
    checks++; if (m_qp_state !== 3'd0) begin errors++; $display("FAIL err_on_reset: got %0d want 0", m_qp_state); end
  endtask

  task automatic test_cfg();
    set_cfg(24'h000102, 3'd3, 32'hDEADBEEF, 24'h000211, 24'h000010, 24'h000077, 32'h0A000001, 64'h1000);
    @(negedge clk); idle_inputs();
    lookup(24'h000102);
    checks++; if (m_qp_state !== 3'd3) begin errors++; $display("FAIL cfg_state: got %0d want 3", m_qp_state); end
    checks++; if (m_qp_r_key !== 32'hDEADBEEF) begin errors++; $display("FAIL cfg_r_key: got %h want deadbeef", m_qp_r_key); end
    checks++; if (m_qp_rem_qpn !== 24'h000211) begin errors++; $display("FAIL cfg_rem_qpn: got %h want 000211", m_qp_rem_qpn); end
    checks++; if (m_qp_rem_psn !== 24'h000010) begin errors++; $display("FAIL cfg_rem_psn: got %h want 000010", m_qp_rem_psn); end
    checks++; if (m_qp_loc_psn !== 24'h000077) begin errors++; $display("FAIL cfg_loc_psn: got %h want 000077", m_qp_loc_psn); end
    checks++; if (m_qp_rem_ip_addr !== 32'h0A000001) begin errors++; $display("FAIL cfg_rem_ip: got %h want 0a000001", m_qp_rem_ip_addr); end
    checks++; if (m_qp_rem_addr !== 64'h1000) begin errors++; $display("FAIL cfg_rem_addr: got %h want 1000", m_qp_rem_addr); end
    checks++; if (m_qp_loc_qpn !== 24'h000102) begin errors++; $display("FAIL cfg_loc_qpn: got %h want 000102", m_qp_loc_qpn); end
    checks++; if (m_rts_count !== 3'd1) begin errors++; $display("FAIL cfg_rts_count: got %0d want 1", m_rts_count); end
  endtask

  task automatic test_psn_wrap();
    cfg(24'h000102, 3'd3, 24'hFFFFFE);
    psn_upd(24'h000102, 24'd5);
    lookup(24'h000102);
    checks++; if (m_qp_rem_psn !== 24'h000003) begin errors++; $display("FAIL psn_wrap: got %h want 000003", m_qp_rem_psn); end
    cfg(24'h000102, 3'd1, 24'hFFFFFE);
    psn_upd(24'h000102, 24'd5);
    lookup(24'h000102);
    checks++; if (m_qp_rem_psn !== 24'hFFFFFE) begin errors++; $display("FAIL psn_not_rts: got %h want fffffe", m_qp_rem_psn); end
    checks++; if (m_rts_count !== 3'd0) begin errors++; $display("FAIL psn_rts_count: got %0d want 0", m_rts_count); end
    cfg(24'h000103, 3'd7, 24'h0);
    lookup(24'h000103);
    checks++; if (m_qp_state !== 3'd6) begin errors++; $display("FAIL cfg_state7: got %0d want 6", m_qp_state); end
  endtask

  task automatic test_conflict();
    set_cfg(24'h000101, 3'd2, 32'h11112222, 24'h0, 24'h0, 24'h0, 32'h0, 64'h0);
    @(negedge clk); idle_inputs();
    // All three updates on index 0: only the config write survives.
    set_cfg(24'h000100, 3'd3, 32'h0, 24'h0, 24'h000020, 24'h0, 32'h0, 64'h0);
    s_err_valid = 1'b1; s_err_loc_qpn = 24'h000100;
    s_psn_upd_valid = 1'b1; s_psn_upd_loc_qpn = 24'h000100; s_psn_upd_npkts = 24'd4;
    @(negedge clk); idle_inputs();
    lookup(24'h000100);
    checks++; if (m_qp_state !== 3'd3) begin errors++; $display("FAIL prio_state: got %0d want 3", m_qp_state); end
    checks++; if (m_qp_rem_psn !== 24'h000020) begin errors++; $display("FAIL prio_psn: got %h want 000020", m_qp_rem_psn); end
    // Distinct indices in one cycle all apply.
    set_cfg(24'h000102, 3'd1, 32'h0, 24'h0, 24'h000033, 24'h0, 32'h0, 64'h0);
    s_err_valid = 1'b1; s_err_loc_qpn = 24'h000101;
    s_psn_upd_valid = 1'b1; s_psn_upd_loc_qpn = 24'h000100; s_psn_upd_npkts = 24'd4;
    @(negedge clk); idle_inputs();
    lookup(24'h000101);
    checks++; if (m_qp_state !== 3'd6) begin errors++; $display("FAIL err_rtr: got %0d want 6", m_qp_state); end
    checks++; if (m_qp_r_key !== 32'h11112222) begin errors++; $display("FAIL err_keeps_fields: got %h want 11112222", m_qp_r_key); end
    lookup(24'h000100);
    checks++; if (m_qp_rem_psn !== 24'h000024) begin errors++; $display("FAIL multi_psn: got %h want 000024", m_qp_rem_psn); end
    lookup(24'h000102);
    checks++; if (m_qp_rem_psn !== 24'h000033) begin errors++; $display("FAIL multi_cfg: got %h want 000033", m_qp_rem_psn); end
    checks++; if (m_rts_count !== 3'd1) begin errors++; $display("FAIL conflict_rts_count: got %0d want 1", m_rts_count); end
  endtask

  task automatic test_read_before_write();
    cfg(24'h000100, 3'd3, 24'h000010);
    set_cfg(24'h000100, 3'd3, 32'h0, 24'h0, 24'h000050, 24'h0, 32'h0, 64'h0);
    s_qp_context_req = 1'b1; s_qp_local_qpn_req = 24'h000100;
    @(negedge clk); idle_inputs();
    checks++; if (m_qp_rem_psn !== 24'h000010) begin errors++; $display("FAIL rbw_old: got %h want 000010", m_qp_rem_psn); end
    lookup(24'h000100);
    checks++; if (m_qp_rem_psn !== 24'h000050) begin errors++; $display("FAIL rbw_new: got %h want 000050", m_qp_rem_psn); end
  endtask

  task automatic test_invalid_qpn();
    // 0x000104 and 0x000200 alias index 0 in their low bits but must be ignored.
    set_cfg(24'h000104, 3'd1, 32'hAAAA5555, 24'h1, 24'h000999, 24'h1, 32'h1, 64'h1);
    s_err_valid = 1'b1; s_err_loc_qpn = 24'h000200;
    @(negedge clk); idle_inputs();
    psn_upd(24'h000104, 24'd7);
    cfg(24'h000200, 3'd0, 24'h0);
    lookup(24'h000104);
    checks++; if (m_qp_context_valid !== 1'b1) begin errors++; $display("FAIL inv_valid: got %b want 1", m_qp_context_valid); end
    checks++; if (m_qp_state !== 3'd0 || m_qp_r_key !== 32'h0 || m_qp_rem_psn !== 24'h0)
      begin errors++; $display("FAIL inv_fields_104: got state=%0d r_key=%h rem_psn=%h want 0", m_qp_state, m_qp_r_key, m_qp_rem_psn); end
    checks++; if (m_qp_loc_qpn !== 24'h000104) begin errors++; $display("FAIL inv_loc_qpn_104: got %h want 000104", m_qp_loc_qpn); end
    lookup(24'h000200);
    checks++; if ({m_qp_state, m_qp_r_key, m_qp_rem_qpn, m_qp_rem_psn, m_qp_loc_psn, m_qp_rem_ip_addr, m_qp_rem_addr} !== '0)
      begin errors++; $display("FAIL inv_fields_200: got state=%0d rem_psn=%h want 0", m_qp_state, m_qp_rem_psn); end
    checks++; if (m_qp_loc_qpn !== 24'h000200) begin errors++; $display("FAIL inv_loc_qpn_200: got %h want 000200", m_qp_loc_qpn); end
    lookup(24'h000100);
    checks++; if (m_qp_state !== 3'd3 || m_qp_rem_psn !== 24'h000050 || m_qp_r_key !== 32'h0)
      begin errors++; $display("FAIL inv_untouched: got state=%0d rem_psn=%h r_key=%h want 3/000050/0", m_qp_state, m_qp_rem_psn, m_qp_r_key); end
    checks++; if (m_rts_count !== 3'd1) begin errors++; $display("FAIL inv_rts_count: got %0d want 1", m_rts_count); end
  endtask

  task automatic test_back_to_back();
    s_qp_context_req = 1'b1; s_qp_local_qpn_req = 24'h000100;
    @(negedge clk); s_qp_local_qpn_req = 24'h000101;
    checks++; if (m_qp_context_valid !== 1'b1 || m_qp_loc_qpn !== 24'h000100 || m_qp_state !== 3'd3)
      begin errors++; $display("FAIL b2b_0: got v=%b qpn=%h st=%0d want 1/000100/3", m_qp_context_valid, m_qp_loc_qpn, m_qp_state); end
    @(negedge clk); s_qp_local_qpn_req = 24'h000102;
    checks++; if (m_qp_context_valid !== 1'b1 || m_qp_loc_qpn !== 24'h000101 || m_qp_state !== 3'd6)
      begin errors++; $display("FAIL b2b_1: got v=%b qpn=%h st=%0d want 1/000101/6", m_qp_context_valid, m_qp_loc_qpn, m_qp_state); end
    @(negedge clk); idle_inputs();
    checks++; if (m_qp_context_valid !== 1'b1 || m_qp_loc_qpn !== 24'h000102 || m_qp_state !== 3'd1)
      begin errors++; $display("FAIL b2b_2: got v=%b qpn=%h st=%0d want 1/000102/1", m_qp_context_valid, m_qp_loc_qpn, m_qp_state); end
    @(negedge clk);
    checks++; if (m_qp_context_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", m_qp_context_valid); end
  endtask

  task automatic test_reset_mid_lookup();
    s_qp_context_req = 1'b1; s_qp_local_qpn_req = 24'h000100;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); idle_inputs();
    checks++; if (m_qp_context_valid !== 1'b0 || m_qp_state !== 3'd0 || m_qp_loc_qpn !== 24'h0)
      begin errors++; $display("FAIL rst_mid: got v=%b st=%0d qpn=%h want 0/0/0", m_qp_context_valid, m_qp_state, m_qp_loc_qpn); end
    checks++; if (m_rts_count !== 3'd0) begin errors++; $display("FAIL rst_mid_rts: got %0d want 0", m_rts_count); end
    rst = 1'b0;
    @(negedge clk);
    lookup(24'h000100);
    checks++; if (m_qp_state !== 3'd0 || m_qp_rem_psn !== 24'h0)
      begin errors++; $display("FAIL rst_clears_table: got st=%0d rem_psn=%h want 0/0", m_qp_state, m_qp_rem_psn); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    s_cfg_loc_qpn = '0; s_cfg_state = '0; s_cfg_r_key = '0; s_cfg_rem_qpn = '0;
    s_cfg_rem_psn = '0; s_cfg_loc_psn = '0; s_cfg_rem_ip_addr = '0; s_cfg_rem_addr = '0;
    s_psn_upd_loc_qpn = '0; s_psn_upd_npkts = '0; s_err_loc_qpn = '0; s_qp_local_qpn_req = '0;
    @(negedge clk);
    test_reset();
    test_cfg();
    test_psn_wrap();
    test_conflict();
    test_read_before_write();
    test_invalid_qpn();
    test_back_to_back();
    test_reset_mid_lookup();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
